pcc_stream_ctrl: RTL and testbench

- Sequencer that evaluates one wide binarized-neuron job, a POS_W*NSLICE-bit positive vector and a NEG_W*NSLICE-bit negative vector, by time-multiplexing one external approximate pos/neg popcount pair.
- Each cycle it presents one slice to the counters and accumulates cnt_pos - cnt_neg into a signed saturating accumulator.
- At the end it emits the decision acc >= thr.
- It sits between the layer scheduler (valid/ready job stream) and the shared approximate counter instances.

---
 rtl/pcc_stream_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pcc_stream_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcc_stream_ctrl.sv
// Time-multiplexed binarized-neuron job sequencer: feeds one slice per cycle to a shared
// pos/neg popcount pair and accumulates their difference into a saturating signed accumulator.
module pcc_stream_ctrl #(
  parameter int POS_W  = 2,
  parameter int NEG_W  = 4,
  parameter int PCNT_W = 2,
  parameter int NCNT_W = 3,
  parameter int NSLICE = 8,
  parameter int ACC_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [POS_W*NSLICE-1:0]   pos_bits,
  input  logic [NEG_W*NSLICE-1:0]   neg_bits,
  input  logic [ACC_W-1:0]          thr,
  input  logic                      flush,
  output logic [POS_W-1:0]          slice_pos,
  output logic [NEG_W-1:0]          slice_neg,
  input  logic [PCNT_W-1:0]         cnt_pos,
  input  logic [NCNT_W-1:0]         cnt_neg,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      outval,
  output logic [ACC_W-1:0]          acc_out,
  output logic                      sat
);

  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int SW    = ACC_W + PCNT_W + NCNT_W + 2;
  localparam logic signed [SW-1:0] ACC_MAX = SW'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] ACC_MIN = SW'(-(64'sd1 <<< (ACC_W - 1)));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   thr_q, thr_d;
  logic                      sat_q, sat_d;
  logic [POS_W*NSLICE-1:0]   pos_q, pos_d;
  logic [NEG_W*NSLICE-1:0]   neg_q, neg_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      outval_q, outval_d;
  logic [ACC_W-1:0]          acc_out_q, acc_out_d;
  logic signed [SW-1:0]      sum;

  // Sum is formed wide enough that neither the difference nor the add can wrap before clamping.
  always_comb begin
    sum = SW'(acc_q) + SW'($signed({1'b0, cnt_pos})) - SW'($signed({1'b0, cnt_neg}));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    thr_d   = thr_q;
    sat_d   = sat_q;
    pos_d   = pos_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (!flush && in_valid) begin
          pos_d   = pos_bits;
          neg_d   = neg_bits;
          thr_d   = $signed(thr);
          acc_d   = '0;
          idx_d   = '0;
          sat_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          acc_d   = '0;
          idx_d   = '0;
          sat_d   = 1'b0;
          state_d = IDLE;
        end else begin
          if (sum > ACC_MAX) begin
            acc_d = ACC_MAX[ACC_W-1:0];
            sat_d = 1'b1;
          end else if (sum < ACC_MIN) begin
            acc_d = ACC_MIN[ACC_W-1:0];
            sat_d = 1'b1;
          end else begin
            acc_d = ACC_W'(sum);
          end
          if (idx_q == IDX_W'(NSLICE - 1)) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (flush) begin
          acc_d   = '0;
          idx_d   = '0;
          sat_d   = 1'b0;
          state_d = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake/result outputs are registered from the next-state view so they line up with state_q.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    outval_d    = (state_d == DONE) && (acc_d >= thr_d);
    acc_out_d   = (state_d == DONE) ? acc_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      thr_q       <= '0;
      sat_q       <= 1'b0;
      pos_q       <= '0;
      neg_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      outval_q    <= 1'b0;
      acc_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      thr_q       <= thr_d;
      sat_q       <= sat_d;
      pos_q       <= pos_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      outval_q    <= outval_d;
      acc_out_q   <= acc_out_d;
    end
  end

  always_comb begin
    slice_pos = '0;
    slice_neg = '0;
    if (state_q == RUN) begin
      slice_pos = pos_q[idx_q*POS_W +: POS_W];
      slice_neg = neg_q[idx_q*NEG_W +: NEG_W];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign outval    = outval_q;
  assign acc_out   = acc_out_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_pcc_stream_ctrl.sv
// Bench for pcc_stream_ctrl: NSLICE=4 with popcount counter models, plus a 4-bit accumulator
// instance driven in lockstep for the saturation cases.
module tb_pcc_stream_ctrl;
  localparam int POS_W  = 2;
  localparam int NEG_W  = 4;
  localparam int PCNT_W = 2;
  localparam int NCNT_W = 3;
  localparam int NSLICE = 4;
  localparam int ACC_W  = 8;
  localparam int ACC_W4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, flush, out_ready, approx;
  logic [7:0]  pos_bits;
  logic [15:0] neg_bits;
  logic [7:0]  thr;
  logic [3:0]  thr4;

  logic        in_ready, out_valid, outval, sat;
  logic [1:0]  slice_pos, cnt_pos;
  logic [3:0]  slice_neg;
  logic [2:0]  cnt_neg;
  logic [7:0]  acc_out;

  logic        in_ready4, out_valid4, outval4, sat4;
  logic [1:0]  slice_pos4, cnt_pos4;
  logic [3:0]  slice_neg4;
  logic [2:0]  cnt_neg4;
  logic [3:0]  acc_out4;

  assign thr4 = thr[3:0];

  always_comb begin
    cnt_pos  = PCNT_W'($countones(slice_pos));
    cnt_neg  = approx ? 3'd2 : NCNT_W'($countones(slice_neg));
    cnt_pos4 = PCNT_W'($countones(slice_pos4));
    cnt_neg4 = approx ? 3'd2 : NCNT_W'($countones(slice_neg4));
  end

  pcc_stream_ctrl #(.POS_W(POS_W), .NEG_W(NEG_W), .PCNT_W(PCNT_W), .NCNT_W(NCNT_W),
                    .NSLICE(NSLICE), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pos_bits(pos_bits), .neg_bits(neg_bits), .thr(thr), .flush(flush),
    .slice_pos(slice_pos), .slice_neg(slice_neg), .cnt_pos(cnt_pos), .cnt_neg(cnt_neg),
    .out_valid(out_valid), .out_ready(out_ready), .outval(outval), .acc_out(acc_out), .sat(sat)
  );

  pcc_stream_ctrl #(.POS_W(POS_W), .NEG_W(NEG_W), .PCNT_W(PCNT_W), .NCNT_W(NCNT_W),
                    .NSLICE(NSLICE), .ACC_W(ACC_W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .pos_bits(pos_bits), .neg_bits(neg_bits), .thr(thr4), .flush(flush),
    .slice_pos(slice_pos4), .slice_neg(slice_neg4), .cnt_pos(cnt_pos4), .cnt_neg(cnt_neg4),
    .out_valid(out_valid4), .out_ready(out_ready), .outval(outval4), .acc_out(acc_out4), .sat(sat4)
  );

  typedef struct {
    logic [7:0]  pos;
    logic [15:0] neg;
    logic [7:0]  thr;
    logic        approx;
    logic [7:0]  acc;
    logic        ov;
    logic        sat;
    logic        chk4;
    logic [3:0]  acc4;
    logic        ov4;
    logic        sat4;
  } vec_t;

  vec_t tbl[8];
  vec_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_outval"}, outval, 0);
    check({tag, "_acc_out"}, acc_out, 0);
    check({tag, "_sat"}, sat, 0);
    check({tag, "_slice_pos"}, slice_pos, 0);
    check({tag, "_slice_neg"}, slice_neg, 0);
  endtask

  task automatic run_job(input vec_t v, input bit bp);
    int         cyc;
    logic       got;
    vec_t       e;
    logic [7:0] p;
    logic [15:0] n;
    logic [7:0] held_acc;
    logic       held_ov;
    p = v.pos;
    n = v.neg;
    @(negedge clk);
    out_ready = bp ? 1'b0 : 1'b1;
    pos_bits  = v.pos;
    neg_bits  = v.neg;
    thr       = v.thr;
    approx    = v.approx;
    in_valid  = 1'b1;
    sbq.push_back(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pos_bits = ~v.pos;
    neg_bits = ~v.neg;
    thr      = ~v.thr;
    check("in_ready_run", in_ready, 0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      if (cyc < NSLICE) begin
        check("slice_pos", slice_pos, p[cyc*POS_W +: POS_W]);
        check("slice_neg", slice_neg, n[cyc*NEG_W +: NEG_W]);
      end
      @(posedge clk);
      #1;
      cyc++;
      got = out_valid;
    end
    check("latency", cyc, NSLICE);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("acc_out", acc_out, e.acc);
      check("outval", outval, e.ov);
      check("sat", sat, e.sat);
      if (e.chk4) begin
        check("acc_out4", acc_out4, e.acc4);
        check("outval4", outval4, e.ov4);
        check("sat4", sat4, e.sat4);
      end
    end
    if (bp) begin
      held_acc = acc_out;
      held_ov  = outval;
      for (int k = 0; k < 3; k++) begin
        in_valid = 1'b1;
        pos_bits = 8'hAA;
        neg_bits = 16'h5555;
        @(posedge clk);
        #1;
        check("bp_out_valid", out_valid, 1);
        check("bp_acc_out", acc_out, held_acc);
        check("bp_outval", outval, held_ov);
        check("bp_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    int seen;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    approx    = 1'b0;
    pos_bits  = '0;
    neg_bits  = '0;
    thr       = '0;

    tbl[0] = '{8'hFF, 16'h0000, 8'h00, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 16'hFFFF, 8'hF0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 16'hFFFF, 8'hF1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 16'h0000, 8'h07, 1'b0, 8'h08, 1'b1, 1'b0, 1'b1, 4'h7, 1'b1, 1'b1};
    tbl[4] = '{8'h00, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0};
    tbl[5] = '{8'h0F, 16'h00F0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 16'h0000, 8'h00, 1'b1, 8'hF8, 1'b0, 1'b0, 1'b1, 4'h8, 1'b0, 1'b0};
    tbl[7] = '{8'h9C, 16'h1234, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_job(tbl[i], 1'b0);

    run_job(tbl[7], 1'b1);

    // Asynchronous reset after two slices have been accumulated.
    @(negedge clk);
    pos_bits = 8'hFF;
    neg_bits = 16'h0000;
    thr      = 8'h00;
    approx   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_job(tbl[5], 1'b0);

    // Flush in the third RUN cycle.
    @(negedge clk);
    pos_bits = 8'hFF;
    neg_bits = 16'h0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("flush_no_result", seen, 0);

    // Flush in IDLE wins over a concurrent offer.
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("idle_flush_in_ready", in_ready, 1);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("idle_flush_no_result", seen, 0);

    run_job(tbl[6], 1'b0);
    check("scoreboard_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
